// File: rtl/mem_access_arbiter_if.sv
// Request/grant, read-return and memory command signals shared by the two
// requesters, the arbiter and the single-port memory.
interface mem_access_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req0_i;
  logic                  we0_i;
  logic [DATA_WIDTH-1:0] addr0_i;
  logic [DATA_WIDTH-1:0] wdata0_i;
  logic                  gnt0_o;
  logic                  rvalid0_o;

  logic                  req1_i;
  logic                  we1_i;
  logic [DATA_WIDTH-1:0] addr1_i;
  logic [DATA_WIDTH-1:0] wdata1_i;
  logic                  gnt1_o;
  logic                  rvalid1_o;

  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  err_o;

  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  req0_i, we0_i, addr0_i, wdata0_i,
    input  req1_i, we1_i, addr1_i, wdata1_i,
    input  mem_rdata_i,
    output gnt0_o, rvalid0_o, gnt1_o, rvalid1_o,
    output rdata_o, err_o,
    output mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req0_i, we0_i, addr0_i, wdata0_i,
    output req1_i, we1_i, addr1_i, wdata1_i,
    output mem_rdata_i,
    input  gnt0_o, rvalid0_o, gnt1_o, rvalid1_o,
    input  rdata_o, err_o,
    input  mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter and access sequencer placing an instruction-fetch port (0)
// and a load/store port (1) in front of one single-port memory.
//
// state  | meaning
// IDLE   | no access in flight; sample requests, pick winner, launch command
// ACCESS | grant/err pulse and single-cycle write strobe; reads start here
// WAIT   | read in flight; counter runs down to the memory read latency
module mem_access_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 64,
  parameter int READ_LATENCY = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  mem_access_arbiter_if.slave bus
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(MEMORY_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT
  } state_t;

  state_t           state;
  logic             owner;
  logic             last_owner;
  logic             we_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt;

  logic                  pick1;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_err;

  // Port 1 wins when alone, or on a tie when port 0 owned the previous access.
  always_comb begin
    pick1     = bus.req1_i & (~bus.req0_i | ~last_owner);
    sel_we    = pick1 ? bus.we1_i    : bus.we0_i;
    sel_addr  = pick1 ? bus.addr1_i  : bus.addr0_i;
    sel_wdata = pick1 ? bus.wdata1_i : bus.wdata0_i;
    sel_err   = (sel_addr >= DEPTH_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      owner           <= 1'b0;
      last_owner      <= 1'b1;
      we_q            <= 1'b0;
      err_q           <= 1'b0;
      cnt             <= '0;
      bus.gnt0_o      <= 1'b0;
      bus.gnt1_o      <= 1'b0;
      bus.rvalid0_o   <= 1'b0;
      bus.rvalid1_o   <= 1'b0;
      bus.rdata_o     <= '0;
      bus.err_o       <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
    end else begin
      bus.gnt0_o    <= 1'b0;
      bus.gnt1_o    <= 1'b0;
      bus.rvalid0_o <= 1'b0;
      bus.rvalid1_o <= 1'b0;
      bus.err_o     <= 1'b0;
      bus.mem_we_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0_i || bus.req1_i) begin
            bus.mem_addr_o  <= sel_addr;
            bus.mem_wdata_o <= sel_wdata;
            bus.mem_we_o    <= sel_we & ~sel_err;
            bus.err_o       <= sel_err;
            bus.gnt0_o      <= ~pick1;
            bus.gnt1_o      <= pick1;
            we_q            <= sel_we;
            err_q           <= sel_err;
            owner           <= pick1;
            last_owner      <= pick1;
            state           <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_q) begin
            state <= IDLE;
          end else if (READ_LATENCY == 0) begin
            bus.rdata_o   <= err_q ? '0 : bus.mem_rdata_i;
            bus.rvalid0_o <= ~owner;
            bus.rvalid1_o <= owner;
            state         <= IDLE;
          end else begin
            cnt   <= CNT_W'(READ_LATENCY - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            bus.rdata_o   <= err_q ? '0 : bus.mem_rdata_i;
            bus.rvalid0_o <= ~owner;
            bus.rvalid1_o <= owner;
            state         <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
